// File: rtl/of_pkg.sv
// Shared decode constants, field positions and instruction field split for the OF stage.
// The OF_WB_BYPASS_EN build option lives in of_regfile; nothing here depends on it.
package of_pkg;

    localparam logic [4:0] OPC_ST   = 5'b01111;
    localparam logic [4:0] OPC_RET  = 5'b10100;

    localparam logic [1:0] MOD_SEXT = 2'b00;
    localparam logic [1:0] MOD_UNS  = 2'b01;
    localparam logic [1:0] MOD_HIGH = 2'b10;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int I_BIT   = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 22;
    localparam int RS1_MSB = 21;
    localparam int RS1_LSB = 18;
    localparam int RS2_MSB = 17;
    localparam int RS2_LSB = 14;
    localparam int MOD_MSB = 17;
    localparam int MOD_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int OFF_MSB = 26;

    typedef struct packed {
        logic [4:0]  opcode;
        logic        i;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [1:0]  mod;
        logic [15:0] imm16;
        logic [26:0] off27;
    } of_fields_t;

    // Fields overlap in the instruction word, so they are split out rather than overlaid.
    function automatic of_fields_t split_ir(input logic [31:0] ir);
        of_fields_t f;
        f.opcode = ir[OPC_MSB:OPC_LSB];
        f.i      = ir[I_BIT];
        f.rd     = ir[RD_MSB:RD_LSB];
        f.rs1    = ir[RS1_MSB:RS1_LSB];
        f.rs2    = ir[RS2_MSB:RS2_LSB];
        f.mod    = ir[MOD_MSB:MOD_LSB];
        f.imm16  = ir[IMM_MSB:0];
        f.off27  = ir[OFF_MSB:0];
        return f;
    endfunction

endpackage

// File: rtl/of_regfile.sv
// Purpose: 2-read/1-write register file; OF_WB_BYPASS_EN forwards a same-cycle write to the read ports.
// Latency: reads combinational, writes land on the rising edge.
// Backpressure: none; writes are never blocked by stall or flush.
module of_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [3:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [3:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] regs [NREGS];

    // Indexes at or above NREGS never match the loop, so they are dropped on write and read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_en && wb_addr == 4'(i)) regs[i] <= wb_data;
            end
        end
    end

    always_comb begin
        ra_data = '0;
        rb_data = '0;
        for (int i = 0; i < NREGS; i++) begin
`ifdef OF_WB_BYPASS_EN
            if (ra_addr == 4'(i)) ra_data = (wb_en && wb_addr == ra_addr) ? wb_data : regs[i];
            if (rb_addr == 4'(i)) rb_data = (wb_en && wb_addr == rb_addr) ? wb_data : regs[i];
`else
            if (ra_addr == 4'(i)) ra_data = regs[i];
            if (rb_addr == 4'(i)) rb_data = regs[i];
`endif
        end
    end

endmodule

// File: rtl/of_stage_pipe.sv
// Purpose: operand-fetch stage (decode, regfile read, immediate, branch target); OF_WB_BYPASS_EN selects write-before-read.
// Latency: one cycle in_* to out_*, one instruction per cycle.
// Backpressure: stall holds the OF/EX register, flush clears out_valid and wins over stall.
module of_stage_pipe
    import of_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [31:0]       in_ir,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [31:0]       out_ir,
    output logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] op_2
);

    localparam logic [3:0] RA_IDX = 4'(NREGS - 1);

    of_fields_t        f;
    logic              is_store;
    logic              is_ret;
    logic [3:0]        ra_addr;
    logic [3:0]        rb_addr;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] off_ext;
    logic [DATA_W-1:0] bt_nxt;
    logic [DATA_W-1:0] op_b_nxt;

    assign f        = split_ir(in_ir);
    assign is_store = (f.opcode == OPC_ST);
    assign is_ret   = (f.opcode == OPC_RET);
    assign ra_addr  = is_ret ? RA_IDX : f.rs1;
    assign rb_addr  = is_store ? f.rd : f.rs2;

    of_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra_addr (ra_addr),
        .ra_data (ra_data),
        .rb_addr (rb_addr),
        .rb_data (rb_data)
    );

    // Modifier 11 is reserved and behaves as sign-extend.
    always_comb begin
        imm_ext = DATA_W'($signed(f.imm16));
        case (f.mod)
            MOD_UNS:  imm_ext = DATA_W'(f.imm16);
            MOD_HIGH: imm_ext = DATA_W'({f.imm16, 16'h0000});
            default:  imm_ext = DATA_W'($signed(f.imm16));
        endcase
    end

    assign op_b_nxt = f.i ? imm_ext : rb_data;
    assign off_ext  = DATA_W'($signed(f.off27));
    assign bt_nxt   = DATA_W'(in_pc) + (off_ext << 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_ir        <= '0;
            branch_target <= '0;
            op_a          <= '0;
            op_b          <= '0;
            op_2          <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            // Bubbles load payload too; EX qualifies everything with out_valid.
            out_valid     <= in_valid;
            out_pc        <= in_pc;
            out_ir        <= in_ir;
            branch_target <= bt_nxt;
            op_a          <= ra_data;
            op_b          <= op_b_nxt;
            op_2          <= rb_data;
        end
    end

endmodule

// File: tb/tb_of_stage_pipe.sv
// Directed bench for of_stage_pipe: arithmetic reference model checked every cycle plus literal checks.
module tb_of_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [9:0]  in_pc;
    logic [31:0] in_ir;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic [9:0]  out_pc;
    logic [31:0] out_ir;
    logic [31:0] branch_target;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    of_stage_pipe #(.PC_W(10), .DATA_W(32), .NREGS(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_ir         (in_ir),
        .stall         (stall),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_ir        (out_ir),
        .branch_target (branch_target),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_2          (op_2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_rf [16];
    logic        m_valid;
    logic [9:0]  m_pc;
    logic [31:0] m_ir, m_bt, m_a, m_b, m_2;

    function automatic logic [31:0] m_read(input int idx);
        if (idx >= 16) return 32'd0;
`ifdef OF_WB_BYPASS_EN
        if (wb_en && int'(wb_addr) == idx) return wb_data;
`endif
        return m_rf[idx];
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ir);
        longint v;
        longint imm16;
        int     md;
        imm16 = longint'(ir) % 65536;
        md    = int'((ir / 65536) % 4);
        if (md == 1)      v = imm16;
        else if (md == 2) v = imm16 * 65536;
        else              v = (imm16 >= 32768) ? imm16 - 65536 : imm16;
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_branch(input logic [9:0] pc, input logic [31:0] ir);
        longint off;
        off = longint'(ir) % 134217728;
        if (off >= 67108864) off = off - 134217728;
        return 32'(longint'(pc) + off * 4);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 0; m_pc = 0; m_ir = 0; m_bt = 0; m_a = 0; m_b = 0; m_2 = 0;
            for (int i = 0; i < 16; i++) m_rf[i] = 0;
        end else begin
            int opc, pa, pb;
            opc = int'(in_ir / 32'h0800_0000);
            pa  = (opc == 20) ? 15 : int'((in_ir / 32'h4_0000) % 16);
            pb  = (opc == 15) ? int'((in_ir / 32'h40_0000) % 16) : int'((in_ir / 32'h4000) % 16);
            if (flush) m_valid = 0;
            else if (!stall) begin
                m_valid = in_valid;
                m_pc    = in_pc;
                m_ir    = in_ir;
                m_bt    = m_branch(in_pc, in_ir);
                m_a     = m_read(pa);
                m_2     = m_read(pb);
                m_b     = in_ir[26] ? m_imm(in_ir) : m_read(pb);
            end
            if (wb_en) m_rf[wb_addr] = wb_data;
        end
    end

    always @(negedge clk) begin
        chk("cyc_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("cyc_pc", {22'd0, out_pc}, {22'd0, m_pc});
        chk("cyc_ir", out_ir, m_ir);
        chk("cyc_bt", branch_target, m_bt);
        chk("cyc_op_a", op_a, m_a);
        chk("cyc_op_b", op_b, m_b);
        chk("cyc_op_2", op_2, m_2);
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [31:0] mk(input logic [4:0] opc, input logic i, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [17:0] low);
        return {opc, i, rd, rs1, low};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 0;
    endtask

    task automatic issue(input logic [9:0] pc, input logic [31:0] ir);
        in_valid = 1; in_pc = pc; in_ir = ir;
        tick();
    endtask

    initial begin
        reset = 1; in_valid = 0; in_pc = 0; in_ir = 0; stall = 0; flush = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        reset = 0;

        wr(4'd2, 32'd5);
        issue(10'd4, mk(5'd0, 1'b1, 4'd1, 4'd2, {2'b00, 16'hFFFF}));
        chk("sext_op_a", op_a, 32'd5);
        chk("sext_op_b", op_b, 32'hFFFF_FFFF);
        chk("sext_valid", {31'd0, out_valid}, 32'd1);
        issue(10'd8, mk(5'd0, 1'b1, 4'd1, 4'd2, {2'b01, 16'hFFFF}));
        chk("uns_op_b", op_b, 32'h0000_FFFF);
        issue(10'd12, mk(5'd0, 1'b1, 4'd1, 4'd2, {2'b10, 16'hFFFF}));
        chk("high_op_b", op_b, 32'hFFFF_0000);
        issue(10'd16, mk(5'd0, 1'b1, 4'd1, 4'd2, {2'b11, 16'h8001}));
        chk("mod11_op_b", op_b, 32'hFFFF_8001);

        in_valid = 0;
        wr(4'd3, 32'hAA);
        wr(4'd4, 32'h10);
        wr(4'd15, 32'h40);
        issue(10'd20, mk(5'b01111, 1'b0, 4'd3, 4'd4, 18'd0));
        chk("st_op_2", op_2, 32'hAA);
        chk("st_op_a", op_a, 32'h10);
        issue(10'd24, mk(5'b10100, 1'b0, 4'd0, 4'd0, 18'd0));
        chk("ret_op_a", op_a, 32'h40);

        issue(10'd100, {5'b10000, 27'h7FF_FFFD});
        chk("bt_neg", branch_target, 32'd88);
        issue(10'd1020, {5'b10000, 27'd2});
        chk("bt_pos", branch_target, 32'd1028);

        issue(10'd200, mk(5'd0, 1'b1, 4'd1, 4'd2, {2'b01, 16'h1234}));
        chk("pre_stall_pc", {22'd0, out_pc}, 32'd200);
        stall = 1; in_pc = 10'd300; in_ir = mk(5'd0, 1'b0, 4'd1, 4'd3, 18'd0);
        tick(); tick();
        chk("stall_pc", {22'd0, out_pc}, 32'd200);
        chk("stall_op_b", op_b, 32'h1234);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        flush = 1;
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_pc", {22'd0, out_pc}, 32'd200);
        stall = 0; flush = 0; in_valid = 0;
        tick();
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_pc", {22'd0, out_pc}, 32'd300);

        wb_en = 1; wb_addr = 4'd2; wb_data = 32'h77;
        issue(10'd40, mk(5'd0, 1'b0, 4'd1, 4'd2, {4'd0, 14'd0}));
        wb_en = 0;
`ifdef OF_WB_BYPASS_EN
        chk("wr_rd_same", op_a, 32'h77);
`else
        chk("wr_rd_same", op_a, 32'd5);
`endif
        issue(10'd44, mk(5'd0, 1'b0, 4'd1, 4'd2, {4'd0, 14'd0}));
        chk("wr_landed", op_a, 32'h77);

        #2 reset = 1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_op_a", op_a, 32'd0);
        chk("async_rst_pc", {22'd0, out_pc}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        issue(10'd48, mk(5'd0, 1'b0, 4'd1, 4'd2, {4'd3, 14'd0}));
        chk("post_rst_r2", op_a, 32'd0);
        chk("post_rst_r3", op_b, 32'd0);
        in_valid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
